// File: rtl/display_pkg.sv
// Shared types and helpers for the display scheduler: FSM state encoding,
// default timing constants and small elaboration-time helpers.
package display_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_TX_WAIT,
    S_FINISH,
    S_DWELL
  } sched_state_t;

  localparam int DEFAULT_DWELL_CYCLES   = 4000;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1000000;

  // One bit of a one-hot vector: high when position pos is the selected index.
  function automatic logic onehot_bit(input int idx, input int pos);
    return idx == pos;
  endfunction

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/display_rr_arbiter.sv
// Combinational round-robin picker: first asserted request searching upward
// from ptr_i+1, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [IDX_W-1:0]   cand [NUM_REQ];
  logic [NUM_REQ-1:0] hit;

  // cand[gi] is the requester visited gi+1 steps after the pointer.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cand
    assign cand[gi] = IDX_W'((int'(ptr_i) + gi + 1) % NUM_REQ);
    assign hit[gi]  = req_i[cand[gi]];
  end

  always_comb begin
    valid_o = |hit;
    idx_o   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (hit[k]) begin
        idx_o = cand[k];
      end
    end
  end

endmodule

// File: rtl/display_scheduler.sv
// Time-shares one display path between NUM_REQ requesters: round-robin grant,
// single strobe per value, wait for transfer end (or timeout), then a minimum dwell.
module display_scheduler
  import display_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 16,
  parameter int DWELL_CYCLES   = DEFAULT_DWELL_CYCLES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [NUM_REQ-1:0]          req_i,
  input  logic [NUM_REQ*DATA_W-1:0]   data_i,
  output logic [NUM_REQ-1:0]          grant_o,
  output logic [NUM_REQ-1:0]          done_o,
  output logic [DATA_W-1:0]           disp_data_o,
  output logic                        disp_strobe_o,
  input  logic                        disp_busy_i,
  input  logic                        disp_ack_err_i,
  output logic [$clog2(NUM_REQ)-1:0]  owner_o,
  output logic                        err_o
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(max_int(DWELL_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DWELL_LAST   =
    CNT_W'((DWELL_CYCLES > 0) ? DWELL_CYCLES - 1 : 0);

  sched_state_t         state_q;
  logic [NUM_REQ-1:0]   grant_q;
  logic [NUM_REQ-1:0]   done_q;
  logic [DATA_W-1:0]    data_q;
  logic                 strobe_q;
  logic                 err_q;
  logic [IDX_W-1:0]     owner_q;
  logic [IDX_W-1:0]     ptr_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 seen_busy_q;
  logic                 nack_q;

  logic                 arb_valid;
  logic [IDX_W-1:0]     arb_idx;
  logic [NUM_REQ-1:0]   grant_d;
  logic [DATA_W-1:0]    data_d;
  logic [DATA_W-1:0]    data_slices [NUM_REQ];
  logic                 seen_busy_d;
  logic                 nack_d;
  logic                 tx_end;
  logic                 tx_timeout;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .valid_o (arb_valid),
    .idx_o   (arb_idx)
  );

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign data_slices[gi] = data_i[gi*DATA_W +: DATA_W];
    assign grant_d[gi]     = onehot_bit(int'(arb_idx), gi);
  end

  assign data_d = data_slices[arb_idx];

  // Busy already high in the strobe cycle is captured in SEND, so a fast
  // display path that drops busy on the first TX_WAIT cycle still ends cleanly.
  assign seen_busy_d = seen_busy_q | disp_busy_i;
  assign nack_d      = nack_q | disp_ack_err_i;
  assign tx_end      = seen_busy_q && !disp_busy_i;
  assign tx_timeout  = (cnt_q == TIMEOUT_LAST);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      grant_q     <= '0;
      done_q      <= '0;
      data_q      <= '0;
      strobe_q    <= 1'b0;
      err_q       <= 1'b0;
      owner_q     <= '0;
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      cnt_q       <= '0;
      seen_busy_q <= 1'b0;
      nack_q      <= 1'b0;
    end else begin
      strobe_q <= 1'b0;
      done_q   <= '0;
      err_q    <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (arb_valid) begin
            data_q   <= data_d;
            owner_q  <= arb_idx;
            grant_q  <= grant_d;
            strobe_q <= 1'b1;
            state_q  <= S_SEND;
          end
        end
        S_SEND: begin
          seen_busy_q <= disp_busy_i;
          nack_q      <= 1'b0;
          cnt_q       <= '0;
          state_q     <= S_TX_WAIT;
        end
        S_TX_WAIT: begin
          seen_busy_q <= seen_busy_d;
          nack_q      <= nack_d;
          cnt_q       <= cnt_q + CNT_W'(1);
          if (tx_end || tx_timeout) begin
            done_q  <= grant_q;
            err_q   <= (tx_timeout && !tx_end) || nack_d;
            state_q <= S_FINISH;
          end
        end
        S_FINISH: begin
          ptr_q <= owner_q;
          cnt_q <= '0;
          if (DWELL_CYCLES > 0) begin
            state_q <= S_DWELL;
          end else begin
            grant_q <= '0;
            state_q <= S_IDLE;
          end
        end
        S_DWELL: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // Dwell runs to completion regardless of what the owner does with req.
          if (cnt_q == DWELL_LAST) begin
            grant_q <= '0;
            cnt_q   <= '0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign grant_o       = grant_q;
  assign done_o        = done_q;
  assign disp_data_o   = data_q;
  assign disp_strobe_o = strobe_q;
  assign owner_o       = owner_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_display_scheduler.sv
// Scenario bench for display_scheduler with a simple display-path model and a
// transaction scoreboard (expected pushed at stimulus, observed captured on done_o).
module tb_display_scheduler;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 16;
  localparam int DWELL   = 16;
  localparam int TMO     = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [63:0] data = '0;
  logic        busy = 1'b0;
  logic        ack_err = 1'b0;
  logic [3:0]  grant_o, done_o;
  logic [15:0] disp_data_o;
  logic        disp_strobe_o, err_o;
  logic [1:0]  owner_o;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_strobe = 0;
  int tx_mode = 0;   // 0 normal, 1 busy never rises, 2 NACK during busy
  int busy_left = 0;
  bit start_next = 1'b0;

  typedef struct {
    logic [3:0]  grant;
    logic [1:0]  owner;
    logic [15:0] data;
    logic        err;
    int          done_cyc;
    int          strobe_cyc;
  } txn_t;

  txn_t exp_q[$];
  txn_t obs_q[$];
  txn_t mon_t;

  display_scheduler #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .DWELL_CYCLES(DWELL), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .data_i(data),
    .grant_o(grant_o), .done_o(done_o), .disp_data_o(disp_data_o),
    .disp_strobe_o(disp_strobe_o), .disp_busy_i(busy), .disp_ack_err_i(ack_err),
    .owner_o(owner_o), .err_o(err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Display path: busy rises the cycle after the strobe and stays high 3 cycles.
  always @(posedge clk) begin
    #1;
    if (rst) begin
      busy = 1'b0; ack_err = 1'b0; busy_left = 0; start_next = 1'b0;
    end else begin
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin busy = 1'b0; ack_err = 1'b0; end
      end
      if (start_next) begin
        start_next = 1'b0; busy = 1'b1; ack_err = (tx_mode == 2); busy_left = 3;
      end
      if (disp_strobe_o && tx_mode != 1) start_next = 1'b1;
    end
  end

  always @(posedge clk) begin
    #2;
    if (!rst) begin
      if (disp_strobe_o) last_strobe = cyc;
      if (done_o != 4'b0) begin
        mon_t.grant = done_o; mon_t.owner = owner_o; mon_t.data = disp_data_o;
        mon_t.err = err_o; mon_t.done_cyc = cyc; mon_t.strobe_cyc = last_strobe;
        obs_q.push_back(mon_t);
      end
    end
  end

  task automatic tick();
    @(posedge clk); #3;
  endtask

  task automatic wait_obs(input int budget, output bit ok);
    ok = (obs_q.size() > 0);
    for (int i = 0; i < budget && !ok; i++) begin tick(); ok = (obs_q.size() > 0); end
  endtask

  task automatic wait_strobe(input int budget, output bit ok);
    ok = disp_strobe_o;
    for (int i = 0; i < budget && !ok; i++) begin tick(); ok = disp_strobe_o; end
  endtask

  task automatic push_exp(input logic [3:0] g, input logic [1:0] o, input logic [15:0] d, input logic e);
    txn_t t;
    t.grant = g; t.owner = o; t.data = d; t.err = e; t.done_cyc = 0; t.strobe_cyc = 0;
    exp_q.push_back(t);
  endtask

  task automatic test_reset();
    tick();
    vectors++;
    if ({grant_o, done_o, disp_strobe_o, err_o} !== 10'b0) begin
      $display("FAIL reset_ctrl: grant=%b done=%b strobe=%b err=%b, required all 0", grant_o, done_o, disp_strobe_o, err_o);
      miscompares++;
    end
    vectors++;
    if ({disp_data_o, owner_o} !== 18'b0) begin
      $display("FAIL reset_data: data=%h owner=%0d, required 0000/0", disp_data_o, owner_o);
      miscompares++;
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    txn_t e, o; bit ok; int n;
    data[0 +: 16] = 16'h1234; req = 4'b0001;
    push_exp(4'b0001, 2'd0, 16'h1234, 1'b0);
    vectors++;
    if (disp_strobe_o !== 1'b0) begin $display("FAIL single_pre_strobe: strobe=%b, required 0", disp_strobe_o); miscompares++; end
    tick();
    vectors++;
    if ({disp_strobe_o, grant_o, disp_data_o} !== {1'b1, 4'b0001, 16'h1234}) begin
      $display("FAIL single_latency: strobe=%b grant=%b data=%h, required 1/0001/1234", disp_strobe_o, grant_o, disp_data_o);
      miscompares++;
    end
    tick();
    vectors++;
    if (disp_strobe_o !== 1'b0) begin $display("FAIL single_strobe_width: strobe=%b, required 0", disp_strobe_o); miscompares++; end
    req = 4'b0000;
    wait_obs(200, ok);
    vectors++;
    if (!ok) begin $display("FAIL single_done: actual no done_o, required pulse within 200 cycles"); miscompares++; end
    else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      $display("txn single: done=%b owner=%0d data=%h err=%b", o.grant, o.owner, o.data, o.err);
      if ({o.grant, o.owner, o.data, o.err} !== {e.grant, e.owner, e.data, e.err}) begin
        $display("FAIL single_txn: done=%b owner=%0d data=%h err=%b, required %b/%0d/%h/%b", o.grant, o.owner, o.data, o.err, e.grant, e.owner, e.data, e.err);
        miscompares++;
      end
      n = 0; tick();
      while (grant_o != 4'b0 && n < 100) begin n++; tick(); end
      vectors++;
      if (n != DWELL) begin $display("FAIL single_dwell: grant held %0d cycles after done, required %0d", n, DWELL); miscompares++; end
    end
  endtask

  task automatic test_contention();
    txn_t e, o; bit ok; int prev_done;
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    for (int k = 0; k < 4; k++) data[k*16 +: 16] = 16'hA000 + 16'(k);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) push_exp(4'b0001 << (k % 4), 2'(k % 4), 16'hA000 + 16'(k % 4), 1'b0);
    prev_done = 0;
    for (int k = 0; k < 5; k++) begin
      wait_obs(200, ok);
      vectors++;
      if (!ok) begin $display("FAIL contention_done%0d: actual no done_o, required pulse", k); miscompares++; break; end
      e = exp_q.pop_front(); o = obs_q.pop_front();
      $display("txn contention%0d: done=%b owner=%0d data=%h err=%b", k, o.grant, o.owner, o.data, o.err);
      if ({o.grant, o.owner, o.data, o.err} !== {e.grant, e.owner, e.data, e.err}) begin
        $display("FAIL contention_txn%0d: done=%b owner=%0d data=%h err=%b, required %b/%0d/%h/%b", k, o.grant, o.owner, o.data, o.err, e.grant, e.owner, e.data, e.err);
        miscompares++;
      end
      if (k > 0) begin
        vectors++;
        if (o.strobe_cyc - prev_done < DWELL + 1) begin
          $display("FAIL contention_gap%0d: %0d cycles done->next strobe, required >= %0d", k, o.strobe_cyc - prev_done, DWELL + 1);
          miscompares++;
        end
      end
      prev_done = o.done_cyc;
      tick();
    end
    req = 4'b0000;
    exp_q.delete();
  endtask

  task automatic test_timeout();
    txn_t e, o; bit ok;
    tx_mode = 1; data[32 +: 16] = 16'hBEEF; req = 4'b0100;
    push_exp(4'b0100, 2'd2, 16'hBEEF, 1'b1);
    wait_obs(300, ok);
    vectors++;
    if (!ok) begin $display("FAIL timeout_done: actual no done_o, required pulse"); miscompares++; end
    else begin
      req = 4'b0000;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      $display("txn timeout: done=%b owner=%0d data=%h err=%b after %0d cycles", o.grant, o.owner, o.data, o.err, o.done_cyc - o.strobe_cyc);
      if ({o.grant, o.owner, o.data, o.err} !== {e.grant, e.owner, e.data, e.err}) begin
        $display("FAIL timeout_txn: done=%b owner=%0d data=%h err=%b, required %b/%0d/%h/%b", o.grant, o.owner, o.data, o.err, e.grant, e.owner, e.data, e.err);
        miscompares++;
      end
      vectors++;
      if (o.done_cyc - o.strobe_cyc != TMO + 1) begin
        $display("FAIL timeout_len: strobe->done %0d cycles, required %0d", o.done_cyc - o.strobe_cyc, TMO + 1);
        miscompares++;
      end
      tick();
      vectors++;
      if ({err_o, done_o} !== 5'b0) begin $display("FAIL timeout_pulse: err=%b done=%b one cycle later, required 0/0000", err_o, done_o); miscompares++; end
    end
    tx_mode = 0; req = 4'b0000;
    data[16 +: 16] = 16'h5555; req = 4'b0010;
    push_exp(4'b0010, 2'd1, 16'h5555, 1'b0);
    wait_obs(200, ok);
    vectors++;
    if (!ok) begin $display("FAIL after_timeout_done: actual no done_o, required pulse"); miscompares++; end
    else begin
      req = 4'b0000;
      e = exp_q.pop_front(); o = obs_q.pop_front();
      $display("txn after_timeout: done=%b owner=%0d data=%h err=%b", o.grant, o.owner, o.data, o.err);
      if ({o.grant, o.owner, o.data, o.err} !== {e.grant, e.owner, e.data, e.err}) begin
        $display("FAIL after_timeout_txn: done=%b owner=%0d data=%h err=%b, required %b/%0d/%h/%b", o.grant, o.owner, o.data, o.err, e.grant, e.owner, e.data, e.err);
        miscompares++;
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_nack();
    txn_t e, o; bit ok;
    tx_mode = 2; data[48 +: 16] = 16'hC0DE; req = 4'b1000;
    push_exp(4'b1000, 2'd3, 16'hC0DE, 1'b1);
    wait_obs(200, ok);
    vectors++;
    if (!ok) begin $display("FAIL nack_done: actual no done_o, required pulse"); miscompares++; end
    else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      $display("txn nack: done=%b owner=%0d data=%h err=%b", o.grant, o.owner, o.data, o.err);
      if ({o.grant, o.owner, o.data, o.err} !== {e.grant, e.owner, e.data, e.err}) begin
        $display("FAIL nack_txn: done=%b owner=%0d data=%h err=%b, required %b/%0d/%h/%b", o.grant, o.owner, o.data, o.err, e.grant, e.owner, e.data, e.err);
        miscompares++;
      end
    end
    req = 4'b0000; tx_mode = 0;
  endtask

  task automatic test_req_drop();
    txn_t e, o; bit ok; int n;
    data[0 +: 16] = 16'h1111; req = 4'b0001;
    push_exp(4'b0001, 2'd0, 16'h1111, 1'b0);
    wait_strobe(100, ok);
    tick(); tick();
    req = 4'b0000; data[0 +: 16] = 16'h2222;
    tick();
    vectors++;
    if (!ok || disp_data_o !== 16'h1111) begin
      $display("FAIL drop_hold: strobe_seen=%b data=%h, required 1/1111", ok, disp_data_o); miscompares++;
    end
    wait_obs(200, ok);
    vectors++;
    if (!ok) begin $display("FAIL drop_done: actual no done_o, required pulse"); miscompares++; end
    else begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      $display("txn req_drop: done=%b owner=%0d data=%h err=%b", o.grant, o.owner, o.data, o.err);
      if ({o.grant, o.owner, o.data, o.err} !== {e.grant, e.owner, e.data, e.err}) begin
        $display("FAIL drop_txn: done=%b owner=%0d data=%h err=%b, required %b/%0d/%h/%b", o.grant, o.owner, o.data, o.err, e.grant, e.owner, e.data, e.err);
        miscompares++;
      end
      n = 0; tick();
      while (grant_o != 4'b0 && n < 100) begin n++; tick(); end
      vectors++;
      if (n != DWELL) begin $display("FAIL drop_dwell: grant held %0d cycles after done, required %0d", n, DWELL); miscompares++; end
      vectors++;
      if (disp_data_o !== 16'h1111) begin $display("FAIL drop_retain: data=%h after dwell, required 1111", disp_data_o); miscompares++; end
    end
  endtask

  task automatic test_reset_mid();
    txn_t e, o; bit ok;
    data[0 +: 16] = 16'h7777; data[16 +: 16] = 16'h6161; data[32 +: 16] = 16'h6262;
    req = 4'b0001;
    wait_strobe(100, ok);
    tick(); tick();
    rst = 1'b1; req = 4'b0000;
    #1;
    vectors++;
    if ({grant_o, done_o, disp_strobe_o, err_o, disp_data_o, owner_o} !== 28'b0) begin
      $display("FAIL rst_mid: strobe_seen=%b grant=%b done=%b strobe=%b err=%b data=%h owner=%0d, required all 0", ok, grant_o, done_o, disp_strobe_o, err_o, disp_data_o, owner_o);
      miscompares++;
    end
    tick(); tick();
    rst = 1'b0; req = 4'b0110;
    vectors++;
    if (obs_q.size() != 0) begin $display("FAIL rst_no_done: %0d done pulses seen, required 0", obs_q.size()); miscompares++; obs_q.delete(); end
    push_exp(4'b0010, 2'd1, 16'h6161, 1'b0);
    push_exp(4'b0100, 2'd2, 16'h6262, 1'b0);
    for (int k = 0; k < 2; k++) begin
      wait_obs(200, ok);
      vectors++;
      if (!ok) begin $display("FAIL rst_done%0d: actual no done_o, required pulse", k); miscompares++; break; end
      e = exp_q.pop_front(); o = obs_q.pop_front();
      $display("txn after_reset%0d: done=%b owner=%0d data=%h err=%b", k, o.grant, o.owner, o.data, o.err);
      if ({o.grant, o.owner, o.data, o.err} !== {e.grant, e.owner, e.data, e.err}) begin
        $display("FAIL rst_txn%0d: done=%b owner=%0d data=%h err=%b, required %b/%0d/%h/%b", k, o.grant, o.owner, o.data, o.err, e.grant, e.owner, e.data, e.err);
        miscompares++;
      end
      if (k == 1) req = 4'b0000;
      tick();
    end
    req = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_timeout();
    test_nack();
    test_req_drop();
    test_reset_mid();
    vectors++;
    if (exp_q.size() != 0) begin $display("FAIL scoreboard_drain: %0d expected left, required 0", exp_q.size()); miscompares++; end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded 200000 time units, required completion");
    $fatal(1, "watchdog");
  end

endmodule
